// File: rtl/bf_core_if.sv
// bf_core_if: bundles the memory bus and byte I/O handshakes of the BrainF core.
//   pc/prg         program address out, opcode back (1-cycle read latency)
//   cursor/mem     data address out, cell value back (1-cycle, read-before-write)
//   out/we         write data and strobe for the cell at cursor
//   dout_*         output byte stream ('.'), valid/ready
//   din_*          input byte stream (','), valid/ready
// master = core side, slave = memory / I/O side.
interface bf_core_if;
  logic [15:0] pc;
  logic [7:0]  prg;
  logic [15:0] cursor;
  logic [7:0]  mem;
  logic [7:0]  out;
  logic        we;
  logic [7:0]  dout_data;
  logic        dout_valid;
  logic        dout_ready;
  logic [7:0]  din_data;
  logic        din_valid;
  logic        din_ready;

  modport master (
    output pc, cursor, out, we, dout_data, dout_valid, din_ready,
    input  prg, mem, dout_ready, din_data, din_valid
  );

  modport slave (
    input  pc, cursor, out, we, dout_data, dout_valid, din_ready,
    output prg, mem, dout_ready, din_data, din_valid
  );
endinterface

// File: rtl/bf_core.sv
// bf_core: BrainF execution core with a hardware loop-return stack.
//   clk      system clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      bf_core_if.master: program/data memory bus and byte I/O handshakes
//   halted   core has stopped (halt opcode, unterminated loop, or error)
//   error    loop stack overflow/underflow seen, sticky until reset
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | memory read in flight for pc/cursor; go SCAN if skipping, else EXEC
// EXEC  | prg/mem valid; execute opcode, may stall on I/O handshakes
// SCAN  | forward skip of a '[' body, tracking bracket nesting in depth
// HALT  | terminal until reset
module bf_core #(
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W     = 16
) (
  input  logic    clk,
  input  logic    reset_n,
  bf_core_if.master bus,
  output logic    halted,
  output logic    error
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_RIGHT = 4'h1;
  localparam logic [3:0] OP_LEFT  = 4'h2;
  localparam logic [3:0] OP_INC   = 4'h3;
  localparam logic [3:0] OP_DEC   = 4'h4;
  localparam logic [3:0] OP_OUT   = 4'h5;
  localparam logic [3:0] OP_IN    = 4'h6;
  localparam logic [3:0] OP_OPEN  = 4'h7;
  localparam logic [3:0] OP_CLOSE = 4'h8;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_SCAN  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        pc_q, pc_d;
  logic [15:0]        cursor_q, cursor_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               halted_q, halted_d;
  logic               error_q, error_d;

  logic [15:0]        stack_q [STACK_DEPTH];
  logic               push_en;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   top_idx;
  logic [15:0]        stack_top;

  logic [3:0]         op;
  logic               mem_nz;
  logic [15:0]        pc_inc;
  logic               unused_prg_hi;

  // Only the low nibble of the opcode byte is decoded.
  assign op            = bus.prg[3:0];
  assign unused_prg_hi = ^bus.prg[7:4];
  assign mem_nz        = (bus.mem != 8'h00);
  assign pc_inc        = pc_q + 16'd1;

  assign push_idx  = IDX_W'(sp_q);
  assign top_idx   = IDX_W'(sp_q - SP_W'(1));
  assign stack_top = stack_q[top_idx];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      pc_q     <= 16'h0000;
      cursor_q <= 16'h0000;
      sp_q     <= '0;
      depth_q  <= '0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cursor_q <= cursor_d;
      sp_q     <= sp_d;
      depth_q  <= depth_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  // Stack entries need no reset: sp defines which ones are live.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[push_idx] <= pc_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cursor_d = cursor_q;
    sp_d     = sp_q;
    depth_d  = depth_q;
    halted_d = halted_q;
    error_d  = error_q;
    push_en  = 1'b0;

    case (state_q)
      S_FETCH: begin
        state_d = (depth_q != '0) ? S_SCAN : S_EXEC;
      end

      S_EXEC: begin
        // Default is "advance"; stalls and stops override it below.
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_HALT: begin
            state_d  = S_HALT;
            pc_d     = pc_q;
            halted_d = 1'b1;
          end
          OP_RIGHT: cursor_d = cursor_q + 16'd1;
          OP_LEFT:  cursor_d = cursor_q - 16'd1;
          OP_OUT: begin
            if (!bus.dout_ready) begin
              state_d = S_EXEC;
              pc_d    = pc_q;
            end
          end
          OP_IN: begin
            if (!bus.din_valid) begin
              state_d = S_EXEC;
              pc_d    = pc_q;
            end
          end
          OP_OPEN: begin
            if (mem_nz) begin
              if (sp_q == SP_W'(STACK_DEPTH)) begin
                state_d  = S_HALT;
                pc_d     = pc_q;
                halted_d = 1'b1;
                error_d  = 1'b1;
              end else begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
              end
            end else begin
              depth_d = DEPTH_W'(1);
            end
          end
          OP_CLOSE: begin
            if (sp_q == '0) begin
              state_d  = S_HALT;
              pc_d     = pc_q;
              halted_d = 1'b1;
              error_d  = 1'b1;
            end else if (mem_nz) begin
              // Re-enter the body just past the matching '['; entry stays pushed.
              pc_d = stack_top + 16'd1;
            end else begin
              sp_d = sp_q - SP_W'(1);
            end
          end
          default: ;
        endcase
      end

      S_SCAN: begin
        if (op == OP_HALT) begin
          // Program ended inside a skipped loop: stop without flagging an error.
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          if (op == OP_OPEN) begin
            depth_d = depth_q + DEPTH_W'(1);
          end else if (op == OP_CLOSE) begin
            depth_d = depth_q - DEPTH_W'(1);
          end
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end

      S_HALT: ;

      default: state_d = S_HALT;
    endcase
  end

  // Output logic: strobes only ever assert in EXEC with the matching opcode.
  always_comb begin
    bus.we         = 1'b0;
    bus.out        = bus.mem;
    bus.dout_valid = 1'b0;
    bus.din_ready  = 1'b0;
    if (state_q == S_EXEC) begin
      case (op)
        OP_INC: begin
          bus.we  = 1'b1;
          bus.out = bus.mem + 8'd1;
        end
        OP_DEC: begin
          bus.we  = 1'b1;
          bus.out = bus.mem - 8'd1;
        end
        OP_OUT: bus.dout_valid = 1'b1;
        OP_IN: begin
          bus.din_ready = 1'b1;
          bus.we        = bus.din_valid;
          bus.out       = bus.din_data;
        end
        default: ;
      endcase
    end
  end

  assign bus.dout_data = bus.mem;
  assign bus.pc        = pc_q;
  assign bus.cursor    = cursor_q;
  assign halted        = halted_q;
  assign error         = error_q;

endmodule
